// File: rtl/ad9228_lane_packer_pkg.sv
// Shared types for the AD9228 lane packer: FSM state encoding and the
// 16-bit zero-extended lane word used on the output stream.
package ad9228_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef logic [SAMPLE_W-1:0] lane_word_t;

endpackage

// File: rtl/ad9228_lane_packer_if.sv
// Output word stream of the lane packer: valid/ready handshake with an
// end-of-frame marker; lane i occupies m_tdata[i*16 +: 16].
interface ad9228_lane_packer_if #(
  parameter int NUM_CH = 4
);
  import ad9228_pkg::*;

  logic [NUM_CH*SAMPLE_W-1:0] m_tdata;
  logic                       m_tvalid;
  logic                       m_tready;
  logic                       m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/ad9228_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push on a full FIFO is
// accepted when a pop happens in the same cycle; pop_data reads 0 when empty.
module ad9228_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CNT_FULL = DEPTH;
  localparam logic [AW:0] FULL_CNT = CNT_FULL[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ad9228_lane_packer.sv
// Collects one sample per AD9228 lane into an aligned word, flags lane skew,
// buffers words in a FWFT FIFO and streams fixed-length frames.
// Optional AD9228_PATTERN_CHECK_EN adds a test-pattern mismatch counter.
module ad9228_lane_packer
  import ad9228_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256,
  parameter int SKEW_MAX   = 1
) (
  input  logic                         dco_div4,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clear_flags,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  ad9228_lane_packer_if.master         m_axis,
  output logic                         locked,
  output logic                         overflow,
  output logic                         skew_err
`ifdef AD9228_PATTERN_CHECK_EN
  ,
  input  logic                         pattern_chk,
  input  logic [DATA_WIDTH-1:0]        pattern,
  output logic [15:0]                  pattern_err_cnt
`endif
);

  localparam int WORD_W = NUM_CH * SAMPLE_W;
  localparam int FC_W   = $clog2(FRAME_LEN);
  localparam int AGE_W  = $clog2(SKEW_MAX + 2);
  localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT  = AGE_W'(SKEW_MAX);

  state_t                   state_q, state_d;
  logic [NUM_CH-1:0]        pending_q, pending_d;
  lane_word_t [NUM_CH-1:0]  hold_q, hold_d;
  lane_word_t [NUM_CH-1:0]  lanes;
  lane_word_t [NUM_CH-1:0]  word_q, word_d;
  logic [AGE_W-1:0]         age_q, age_d;
  logic [FC_W-1:0]          frame_q, frame_d;
  logic                     word_vld_q, word_vld_d;
  logic                     word_last_q, word_last_d;
  logic                     skew_hit;
  logic [NUM_CH-1:0]        merged;

  logic [WORD_W:0]          fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     drop;

  // Current-cycle strobes override the held samples so a set can complete
  // in the same cycle its last lane arrives.
  always_comb begin
    lanes = hold_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid[i]) begin
        lanes[i] = lane_word_t'(ch_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  assign merged = pending_q | ch_valid;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    hold_d      = hold_q;
    age_d       = age_q;
    frame_d     = frame_q;
    word_d      = word_q;
    word_vld_d  = 1'b0;
    word_last_d = 1'b0;
    skew_hit    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pending_d = '0;
        age_d     = '0;
        frame_d   = '0;
        if (enable) state_d = ST_ALIGN;
      end

      ST_ALIGN: begin
        pending_d = '0;
        age_d     = '0;
        frame_d   = '0;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (ch_valid == '0) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          pending_d = '0;
          age_d     = '0;
          frame_d   = '0;
        end else if (((ch_valid & pending_q) != '0) ||
                     ((pending_q != '0) && (age_q > AGE_LIMIT))) begin
          skew_hit  = 1'b1;
          state_d   = ST_ALIGN;
          pending_d = '0;
          age_d     = '0;
          frame_d   = '0;
        end else if (&merged) begin
          word_d      = lanes;
          word_vld_d  = 1'b1;
          word_last_d = (frame_q == FRAME_LAST);
          frame_d     = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
          pending_d   = '0;
          age_d       = '0;
        end else begin
          pending_d = merged;
          hold_d    = lanes;
          if (merged != '0) age_d = age_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Set wins over clear on the sticky flags.
  always_ff @(posedge dco_div4) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      hold_q      <= '0;
      age_q       <= '0;
      frame_q     <= '0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      word_last_q <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
      skew_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      hold_q      <= hold_d;
      age_q       <= age_d;
      frame_q     <= frame_d;
      word_q      <= word_d;
      word_vld_q  <= word_vld_d;
      word_last_q <= word_last_d;
      locked      <= (state_q == ST_RUN);
      if (skew_hit) begin
        skew_err <= 1'b1;
      end else if (clear_flags) begin
        skew_err <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
    end
  end

  assign pop  = m_axis.m_tvalid & m_axis.m_tready;
  assign drop = word_vld_q & fifo_full & ~pop;

  ad9228_sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (dco_div4),
    .rst       (rst),
    .push      (word_vld_q),
    .push_data ({word_last_q, word_q}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_axis.m_tvalid = ~fifo_empty;
  assign m_axis.m_tlast  = fifo_dout[WORD_W];
  assign m_axis.m_tdata  = fifo_dout[WORD_W-1:0];

`ifdef AD9228_PATTERN_CHECK_EN
  logic pat_miss;
  logic pat_inc;

  always_comb begin
    pat_miss = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lanes[i] != lane_word_t'(pattern)) pat_miss = 1'b1;
    end
  end

  assign pat_inc = word_vld_d & pattern_chk & pat_miss & (state_q == ST_RUN);

  // Saturating count; an increment coinciding with a clear leaves it at one.
  always_ff @(posedge dco_div4) begin
    if (rst) begin
      pattern_err_cnt <= '0;
    end else if (clear_flags) begin
      pattern_err_cnt <= pat_inc ? 16'd1 : 16'd0;
    end else if (pat_inc && (pattern_err_cnt != 16'hFFFF)) begin
      pattern_err_cnt <= pattern_err_cnt + 16'd1;
    end
  end
`endif

endmodule
